// File: rtl/qpsk_top_if.sv
// qpsk_top_if: serial data in and modulated carrier out of the QPSK modulator
interface qpsk_top_if;
  logic x;
  logic y;
  modport master (output x, input y);
  modport slave (input x, output y);
endinterface

// File: rtl/qpsk_top.sv
// qpsk_top: pairs serial bits into dibits and maps each to one of four phases of a 4-clock square carrier
module qpsk_top (
  input logic       clk,
  input logic       rst,
  qpsk_top_if.slave bus
);
  logic [2:0] cnt_q, cnt_d;
  logic       b_hi_q, b_hi_d;
  logic [1:0] sym_q, sym_d;
  logic       y_q, y_d;
  logic [1:0] ph;
  // Frame counter, dibit capture at cnt 3/7, and carrier sample chosen by phase offset from sym
  always_comb begin
    ph = cnt_q[1:0] - sym_q;
    cnt_d = cnt_q + 3'd1;
    b_hi_d = (cnt_q == 3'd3) ? bus.x : b_hi_q;
    sym_d = (cnt_q == 3'd7) ? {b_hi_q, bus.x} : sym_q;
    y_d = ~ph[1];
  end
  // State registers; reset overrides every update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
      b_hi_q <= 1'b0;
      sym_q <= 2'b00;
      y_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      b_hi_q <= b_hi_d;
      sym_q <= sym_d;
      y_q <= y_d;
    end
  end
  assign bus.y = y_q;
endmodule

// File: tb/tb_qpsk_top.sv
// tb_qpsk_top: directed vector tables of rst/x per edge with hand-computed y after each edge
module tb_qpsk_top;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  qpsk_top_if bus ();
  qpsk_top dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    string name;
    string r;
    string x;
    string y;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string nm, input int idx, input logic exp);
    checks++;
    if (bus.y !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: y=%b expected %b", nm, idx, bus.y, exp);
    end
  endtask
  task automatic step(input logic r, input logic xv);
    rst = r;
    bus.x = xv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // Each string position is one rising edge, starting at E0 after the pre-test reset.
    v[0] = '{"reset_hold", "1111100000000", "1010100000000", "0000011001100"};
    v[1] = '{"const_zero", "", "0000000000000000", "1100110011001100"};
    v[2] = '{"const_one", "", "111111111111111111111111", "110011001001100110011001"};
    v[3] = '{"all_dibits", "",
             "0000111111110000111111110000000000000000",
             "1100110001100110001100111001100111001100"};
    v[4] = '{"off_grid", "",
             "1111100000111110000011111000001111100000",
             "1100110000110011001100110110011001100110"};
    v[5] = '{"reset_mid", "0000010000000000000000",
             "1111110000000000000000",
             "1100101100110011001100"};
    rst = 1'b1;
    bus.x = 1'b0;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 2; k++) begin
        step(1'b1, k[0]);
        chk({v[t].name, "_pre_rst"}, k, 1'b0);
      end
      for (int i = 0; i < v[t].y.len(); i++) begin
        step((i < v[t].r.len()) ? (v[t].r[i] == "1") : 1'b0, v[t].x[i] == "1");
        chk(v[t].name, i, v[t].y[i] == "1");
      end
    end
    // y must not follow x between edges: toggle x inside cycles and re-check y stays put
    step(1'b1, 1'b0);
    chk("comb_rst", 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      chk("comb_edge", i, (i % 4) < 2);
      bus.x = 1'b1;
      #2;
      chk("comb_mid", i, (i % 4) < 2);
      bus.x = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
